// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register controller sitting downstream of the mult and div
// units. It launches one operation, waits the unit's fixed latency, captures
// the selected unit's hi/lo into the architectural HI/LO registers, serves
// mfhi/mflo reads and stalls those reads while an operation is in flight.
// A div with a zero divisor is rejected in IDLE with a one-cycle exception.
//
// Optional feature macro: HILO_WRITE_EN (adds mthi/mtlo write port).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, MultOrDiv, B operation request (0 = mult, 1 = div), divisor
//   mult_hi/lo, div_hi/lo  unit results, sampled only in CAPTURE
//   unit_start          one-cycle launch pulse to the units
//   busy, done          op in flight / one-cycle capture pulse
//   div0_exc            one-cycle pulse: div requested with B == 0
//   rd_req, rd_sel      read request, 0 = HI, 1 = LO
//   rd_data             registered read data
//   stall               combinational read (or write) stall while busy
//   hi, lo              architectural HI/LO registers
//   wr_en/wr_sel/wr_data  (HILO_WRITE_EN only) mthi/mtlo write
//   dbg_state           current FSM state for observation
//
// Handshake: start is a level sampled only in IDLE; it is neither queued nor
// acknowledged while busy. rd_req (and wr_en) complete in the cycle they are
// presented when stall is low; while stall is high they have no effect and
// the requester must hold them until stall falls.
module hilo_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        MultOrDiv,
  input  logic [31:0] B,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        unit_start,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
`ifdef HILO_WRITE_EN
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  // Counter reload values: WAIT lasts exactly N cycles, counting N-1 down to 0.
  localparam logic [CNT_W-1:0] L_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_op;
  logic              r_div0;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;
  logic [31:0]       r_rd_data;
  logic              w_idle;
  logic              w_div0;
  logic              w_accept;

  assign w_idle   = (r_state == S_IDLE);
  assign w_div0   = start & MultOrDiv & (B == 32'd0);
  assign w_accept = w_idle & start & ~w_div0;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT:    if (r_cnt == '0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      r_div0  <= w_idle & w_div0;

      if (w_accept) r_op <= MultOrDiv;

      if (r_state == S_LAUNCH) begin
        r_cnt <= r_op ? L_DIV_LOAD : L_MULT_LOAD;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Reads sample the old HI/LO, so a same-cycle write or capture is not
      // visible until the following read.
      if (rd_req && w_idle) r_rd_data <= rd_sel ? r_lo : r_hi;

      if (r_state == S_CAPTURE) begin
        r_hi <= r_op ? div_hi : mult_hi;
        r_lo <= r_op ? div_lo : mult_lo;
      end
`ifdef HILO_WRITE_EN
      else if (w_idle && wr_en) begin
        if (wr_sel) r_lo <= wr_data;
        else        r_hi <= wr_data;
      end
`endif
    end
  end

  assign unit_start = (r_state == S_LAUNCH);
  assign busy       = ~w_idle;
  assign done       = (r_state == S_CAPTURE);
  assign div0_exc   = r_div0;
  assign rd_data    = r_rd_data;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign dbg_state  = r_state;

`ifdef HILO_WRITE_EN
  assign stall = (rd_req | wr_en) & busy;
`else
  assign stall = rd_req & busy;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: mult, div (with a shorter div latency to
// tell the two apart), divide-by-zero, read stall, start while busy and
// reset mid-operation. Expected values are hand-computed constants tracked
// in a small HI/LO/read-data model.
module tb_hilo_ctrl;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        MultOrDiv;
  logic [31:0] B;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        unit_start, busy, done, div0_exc;
  logic        rd_req, rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;
`ifdef HILO_WRITE_EN
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [31:0] wr_data = '0;
`endif

  int checks = 0;
  int failures = 0;

  // Model of architectural state.
  logic [31:0] m_hi, m_lo, m_rd;

  hilo_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .MultOrDiv (MultOrDiv),
    .B         (B),
    .mult_hi   (mult_hi),
    .mult_lo   (mult_lo),
    .div_hi    (div_hi),
    .div_lo    (div_lo),
    .unit_start(unit_start),
    .busy      (busy),
    .done      (done),
    .div0_exc  (div0_exc),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
`ifdef HILO_WRITE_EN
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
`endif
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one accepted operation. Cycle 1 is LAUNCH, CAPTURE is cycle n+2.
  // rd_at > 0 raises rd_req (LO) from that cycle on; restart_at > 0 pulses a
  // second start at that cycle; pre_rd reads HI in the same cycle as start.
  task automatic run_op(input logic op, input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int rd_at, input int restart_at, input logic pre_rd);
    start = 1'b1; MultOrDiv = op; B = b;
    rd_req = pre_rd; rd_sel = 1'b0;
    tick();
    if (pre_rd) m_rd = m_hi;
    for (int k = 1; k <= n + 2; k++) begin
      start  = (k == restart_at);
      rd_req = (rd_at > 0) && (k >= rd_at);
      rd_sel = 1'b1;
      #1;
      check_eq("op_busy",       busy, 1);
      check_eq("op_unit_start", unit_start, (k == 1));
      check_eq("op_done",       done, (k == n + 2));
      check_eq("op_div0",       div0_exc, 0);
      check_eq("op_stall",      stall, rd_req);
      check_eq("op_rd_hold",    rd_data, m_rd);
      check_eq("op_hi_hold",    hi, m_hi);
      check_eq("op_lo_hold",    lo, m_lo);
      tick();
    end
    start = 1'b0;
    m_hi = ehi; m_lo = elo;
    #1;
    check_eq("post_busy",  busy, 0);
    check_eq("post_done",  done, 0);
    check_eq("post_stall", stall, 0);
    check_eq("post_hi",    hi, m_hi);
    check_eq("post_lo",    lo, m_lo);
    tick();
    if (rd_at > 0) m_rd = elo;
    rd_req = 1'b0;
    check_eq("post_rd_data",    rd_data, m_rd);
    check_eq("post_no_restart", unit_start | busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MultOrDiv = 1'b0; B = '0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    rd_req = 1'b0; rd_sel = 1'b0;
    m_hi = '0; m_lo = '0; m_rd = '0;

    // Reset state
    tick(); tick();
    check_eq("rst_state",      dbg_state, 0);
    check_eq("rst_hi",         hi, 0);
    check_eq("rst_lo",         lo, 0);
    check_eq("rst_rd_data",    rd_data, 0);
    check_eq("rst_busy",       busy, 0);
    check_eq("rst_unit_start", unit_start, 0);
    check_eq("rst_done",       done, 0);
    check_eq("rst_div0",       div0_exc, 0);
    reset = 1'b0;

    // Mult 7 * -3, B = 0 must not raise div0; read LO from cycle 5,
    // second start at cycle 10 must be ignored.
    mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFEB;
    div_hi  = 32'hDEAD_0001; div_lo  = 32'hDEAD_0002;
    run_op(1'b0, 32'd0, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 10, 1'b0);

    // Div 100 / 7 with a same-cycle read of the old HI.
    mult_hi = 32'hAAAA_5555; mult_lo = 32'h5555_AAAA;
    div_hi  = 32'd2;         div_lo  = 32'd14;
    run_op(1'b1, 32'd7, DIV_N, 32'd2, 32'd14, 0, 0, 1'b1);

    // Divide by zero
    start = 1'b1; MultOrDiv = 1'b1; B = 32'd0;
    tick();
    start = 1'b0;
    check_eq("d0_exc",        div0_exc, 1);
    check_eq("d0_busy",       busy, 0);
    check_eq("d0_unit_start", unit_start, 0);
    check_eq("d0_state",      dbg_state, 0);
    tick();
    check_eq("d0_exc_pulse",  div0_exc, 0);
    check_eq("d0_busy2",      busy, 0);
    check_eq("d0_unit_start2", unit_start, 0);
    check_eq("d0_hi",         hi, m_hi);
    check_eq("d0_lo",         lo, m_lo);

    // Idle read of HI
    rd_req = 1'b1; rd_sel = 1'b0;
    #1;
    check_eq("idle_stall", stall, 0);
    tick();
    rd_req = 1'b0;
    m_rd = m_hi;
    check_eq("idle_rd_hi", rd_data, m_rd);

    // Reset at cycle 20 of a mult
    mult_hi = 32'h1234_5678; mult_lo = 32'h9ABC_DEF0;
    start = 1'b1; MultOrDiv = 1'b0; B = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      check_eq("rm_busy", busy, 1);
      check_eq("rm_done", done, 0);
      if (k == 20) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_rd = '0;
    check_eq("rm_state",   dbg_state, 0);
    check_eq("rm_busy0",   busy, 0);
    check_eq("rm_done0",   done, 0);
    check_eq("rm_hi",      hi, 0);
    check_eq("rm_lo",      lo, 0);
    check_eq("rm_rd_data", rd_data, 0);
    // Start accepted right after reset deasserts.
    run_op(1'b0, 32'd3, MULT_N, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sits directly downstream of the mult and div units. Launches one operation, waits its fixed latency, then captures the selected unit's hi/lo into the architectural HI/LO registers.
- Serves mfhi/mflo reads to the datapath and stalls the pipeline while an operation is in flight.
- Detects divide-by-zero before launching a div.

Parameters:
- MULT_CYCLES, 32, cycles the mult unit needs from its start pulse until its hi/lo are valid
- DIV_CYCLES, 32, same for the div unit
- CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request from control unit, sampled in IDLE only
- MultOrDiv  in  1  0 = mult, 1 = div (same encoding as the upstream units)
- B  in  32  divisor operand, used only for zero detection
- mult_hi, mult_lo  in  32 each  mult unit results
- div_hi, div_lo  in  32 each  div remainder / quotient
- unit_start  out  1  one-cycle launch pulse to the mult/div units
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse on capture
- div0_exc  out  1  one-cycle pulse: div requested with B == 0
- rd_req  in  1  mfhi/mflo request
- rd_sel  in  1  0 = HI, 1 = LO
- rd_data  out  32  registered read data
- stall  out  1  combinational: rd_req & busy
- hi, lo  out  32 each  architectural HI/LO registers

Behaviour:
- Reset: synchronous, active-high, one clock. State = IDLE; hi, lo, rd_data, counter, latched op all 0; unit_start, busy, done, div0_exc all 0. Reset takes priority over every other input.
- States: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE, start=1, MultOrDiv=1, B=0: div0_exc=1 next cycle; stay IDLE; hi/lo unchanged; no unit_start.
- IDLE, start=1, otherwise: latch MultOrDiv into op; go to LAUNCH.
- LAUNCH: unit_start=1 for exactly this cycle; counter loads (op ? DIV_CYCLES : MULT_CYCLES) - 1; go to WAIT.
- WAIT: counter decrements each cycle; when counter == 0, go to CAPTURE.
- CAPTURE: hi/lo load {div_hi, div_lo} if op=1, else {mult_hi, mult_lo}; done=1; go to IDLE.
- Latency: start sampled at edge t. LAUNCH in cycle t+1. WAIT for N cycles. CAPTURE in cycle t+2+N. New hi/lo visible after that edge, i.e. at t+3+N.
- busy = 1 in LAUNCH, WAIT and CAPTURE. start while busy is ignored (not queued).
- Reads:
  - rd_req with busy=0: rd_data <= (rd_sel ? lo : hi) at the next edge; stall=0.
  - rd_req with busy=1: stall=1; rd_data holds.
- start and rd_req in the same IDLE cycle: the read returns the pre-operation value; start is accepted.
- Reset mid-operation: abort to IDLE; no done; hi/lo cleared.
- Upstream inputs are ignored outside CAPTURE; no arithmetic is performed here.

Optional Feature:
- Macro: HILO_WRITE_EN.
- Defined: adds ports wr_en (in, 1), wr_sel (in, 1; 0 = HI, 1 = LO), wr_data (in, 32) for mthi/mtlo.
  - In IDLE: the selected register loads wr_data at the edge.
  - While busy: the write is ignored and stall is asserted (stall = (rd_req | wr_en) & busy).
  - Write and read in the same IDLE cycle: read returns the old value.
  - Write and start in the same IDLE cycle: the write lands, then the operation overwrites at CAPTURE.
- Undefined: ports absent; stall = rd_req & busy.

Test Plan:
- Mult: reset, start with MultOrDiv=0; model drives mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFEB (7 * -3) -> unit_start pulses at cycle t+1, done at t+34, hi/lo equal those values at t+35, busy high t+1..t+34.
- Div: start with MultOrDiv=1, B=7; div_lo=14, div_hi=2 (100 / 7) -> lo=14, hi=2 after done; no div0_exc.
- Div by zero: start, MultOrDiv=1, B=0 -> div0_exc one cycle, unit_start never pulses, busy stays 0, hi/lo unchanged.
- Read stall: rd_req=1, rd_sel=1 held from t+5 -> stall=1 until busy drops; rd_data=lo (new value) one edge after stall falls.
- Start while busy: second start at t+10 -> ignored; exactly one done pulse.
- Reset mid-op: reset at t+20 -> IDLE next edge, hi=lo=0, done never pulses, start accepted the cycle after reset deasserts.
